// File: rtl/v68k_pkg.sv
// Shared v68k definitions: CCR bit positions, CCR update modes,
// 68000 condition codes and the condition-evaluation state type.
package v68k_pkg;

  localparam int CCR_X = 4;
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [1:0] {
    UPD_ARITH = 2'b00,
    UPD_EXT   = 2'b01,
    UPD_LOGIC = 2'b10,
    UPD_LOAD  = 2'b11
  } upd_mode_t;

  typedef enum logic [3:0] {
    CC_T  = 4'd0,  CC_F  = 4'd1,  CC_HI = 4'd2,  CC_LS = 4'd3,
    CC_CC = 4'd4,  CC_CS = 4'd5,  CC_NE = 4'd6,  CC_EQ = 4'd7,
    CC_VC = 4'd8,  CC_VS = 4'd9,  CC_PL = 4'd10, CC_MI = 4'd11,
    CC_GE = 4'd12, CC_LT = 4'd13, CC_GT = 4'd14, CC_LE = 4'd15
  } cond_code_t;

  typedef enum logic {
    EVAL_IDLE  = 1'b0,
    EVAL_DEFER = 1'b1
  } eval_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational 68000 condition predicate for Bcc/DBcc/Scc.
// X never takes part in a condition, so only {N,Z,V,C} is taken in.
module cond_eval
  import v68k_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_sel,
  output logic       cond_true
);

  logic n, z, v, c;

  assign n = flags[CCR_N];
  assign z = flags[CCR_Z];
  assign v = flags[CCR_V];
  assign c = flags[CCR_C];

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    cond_true = 1'b0;
    case (cond_code_t'(cond_sel))
      CC_T:    cond_true = 1'b1;
      CC_F:    cond_true = 1'b0;
      CC_HI:   cond_true = ~c & ~z;
      CC_LS:   cond_true = c | z;
      CC_CC:   cond_true = ~c;
      CC_CS:   cond_true = c;
      CC_NE:   cond_true = ~z;
      CC_EQ:   cond_true = z;
      CC_VC:   cond_true = ~v;
      CC_VS:   cond_true = v;
      CC_PL:   cond_true = ~n;
      CC_MI:   cond_true = n;
      CC_GE:   cond_true = ~(n ^ v);
      CC_LT:   cond_true = n ^ v;
      CC_GT:   cond_true = ~(n ^ v) & ~z;
      CC_LE:   cond_true = z | (n ^ v);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ccr_unit.sv
// v68k condition-code register with masked ALU updates and registered
// condition evaluation. Optional feature macro: CCR_BYPASS_EN.
module ccr_unit
  import v68k_pkg::*;
#(
  parameter logic [4:0] RESET_CCR = 5'b00000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       upd_valid,
  input  logic [4:0] upd_mask,
  input  logic [1:0] upd_mode,
  input  logic [4:0] wr_data,
  input  logic       cond_req,
  input  logic [3:0] cond_sel,
  output logic [4:0] ccr,
  output logic       cond_valid,
  output logic       cond_true,
  output logic       cond_busy
);

  logic [4:0]  cand;
  logic [4:0]  next_ccr;
  logic [4:0]  eval_ccr;
  logic [3:0]  eval_sel;
  logic        pred;
  eval_state_t state;

  // Candidate value per mode; the mask then decides which bits actually move.
  always_comb begin
    cand = ccr;
    case (upd_mode_t'(upd_mode))
      UPD_ARITH: cand = {alu_c, alu_n, alu_z, alu_v, alu_c};
      UPD_EXT:   cand = {alu_c, alu_n, alu_z & ccr[CCR_Z], alu_v, alu_c};
      UPD_LOGIC: cand = {ccr[CCR_X], alu_n, alu_z, 1'b0, 1'b0};
      UPD_LOAD:  cand = wr_data;
      default:   cand = ccr;
    endcase
    next_ccr = upd_valid ? ((cand & upd_mask) | (ccr & ~upd_mask)) : ccr;
  end

`ifdef CCR_BYPASS_EN
  // A coincident request sees the CCR as it will be after this edge.
  assign eval_ccr  = next_ccr;
  assign eval_sel  = cond_sel;
  assign cond_busy = 1'b0;
`else
  logic [3:0] sel_q;

  // By the DEFER cycle the update has landed, so the current CCR is correct.
  assign eval_ccr  = ccr;
  assign eval_sel  = (state == EVAL_DEFER) ? sel_q : cond_sel;
  assign cond_busy = (state == EVAL_DEFER);
`endif

  cond_eval u_cond_eval (
    .flags     (eval_ccr[3:0]),
    .cond_sel  (eval_sel),
    .cond_true (pred)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ccr <= RESET_CCR;
    end else begin
      ccr <= next_ccr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EVAL_IDLE;
      cond_valid <= 1'b0;
      cond_true  <= 1'b0;
`ifndef CCR_BYPASS_EN
      sel_q      <= 4'd0;
`endif
    end else begin
      cond_valid <= 1'b0;
      case (state)
        EVAL_IDLE: begin
          if (cond_req) begin
`ifdef CCR_BYPASS_EN
            cond_valid <= 1'b1;
            cond_true  <= pred;
`else
            if (upd_valid) begin
              state <= EVAL_DEFER;
              sel_q <= cond_sel;
            end else begin
              cond_valid <= 1'b1;
              cond_true  <= pred;
            end
`endif
          end
        end
        EVAL_DEFER: begin
          // Any cond_req arriving here is dropped.
          cond_valid <= 1'b1;
          cond_true  <= pred;
          state      <= EVAL_IDLE;
        end
        default: state <= EVAL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard testbench for ccr_unit: a bit-level CCR model predicts updates and
// condition results; expected results are queued with their due cycle.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_c, alu_z, alu_v, alu_n;
  logic       upd_valid;
  logic [4:0] upd_mask;
  logic [1:0] upd_mode;
  logic [4:0] wr_data;
  logic       cond_req;
  logic [3:0] cond_sel;
  logic [4:0] ccr;
  logic       cond_valid, cond_true, cond_busy;

  typedef struct {
    logic exp_true;
    int   due;
  } exp_t;

  exp_t       sb[$];
  exp_t       head;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [4:0] m_ccr = 5'b00000;
  logic       m_busy = 1'b0;
  logic       last_true = 1'b0;

  always #5 clk = ~clk;

  ccr_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .upd_valid  (upd_valid),
    .upd_mask   (upd_mask),
    .upd_mode   (upd_mode),
    .wr_data    (wr_data),
    .cond_req   (cond_req),
    .cond_sel   (cond_sel),
    .ccr        (ccr),
    .cond_valid (cond_valid),
    .cond_true  (cond_true),
    .cond_busy  (cond_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-bit model of the CCR update; nzvc = {N,Z,V,C} from the ALU.
  function automatic logic [4:0] model_next(input logic [4:0] cur, input logic uv,
                                            input logic [4:0] mask, input logic [1:0] mode,
                                            input logic [4:0] wr, input logic [3:0] nzvc);
    logic [4:0] r;
    r = cur;
    if (uv) begin
      for (int i = 0; i < 5; i++) begin
        if (mask[i]) begin
          case (mode)
            2'b00: if (i == 4) r[i] = nzvc[0]; else r[i] = nzvc[i];
            2'b01: begin
              if (i == 4)      r[i] = nzvc[0];
              else if (i == 2) r[i] = nzvc[2] ? cur[2] : 1'b0;
              else             r[i] = nzvc[i];
            end
            2'b10: begin
              if (i == 2 || i == 3) r[i] = nzvc[i];
              else if (i < 2)       r[i] = 1'b0;
            end
            default: r[i] = wr[i];
          endcase
        end
      end
    end
    return r;
  endfunction

  function automatic logic model_pred(input logic [4:0] f, input logic [3:0] sel);
    logic n, z, v, c;
    {n, z, v, c} = f[3:0];
    case (sel)
      4'd0:    return 1'b1;
      4'd1:    return 1'b0;
      4'd2:    return !c && !z;
      4'd3:    return c || z;
      4'd4:    return !c;
      4'd5:    return c;
      4'd6:    return !z;
      4'd7:    return z;
      4'd8:    return !v;
      4'd9:    return v;
      4'd10:   return !n;
      4'd11:   return n;
      4'd12:   return n == v;
      4'd13:   return n != v;
      4'd14:   return (n == v) && !z;
      default: return z || (n != v);
    endcase
  endfunction

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_mask = 5'b0; upd_mode = 2'b0; wr_data = 5'b0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0;
    cond_req = 1'b0; cond_sel = 4'd0;
  endtask

  // One cycle of stimulus; called just after a rising edge.
  task automatic drive(input logic uv, input logic [4:0] mask, input logic [1:0] mode,
                       input logic [4:0] wr, input logic [3:0] nzvc,
                       input logic req, input logic [3:0] sel);
    logic [4:0] nxt;
    logic       nb;
    check("busy", cond_busy, m_busy);
    check("ccr", ccr, m_ccr);
    upd_valid = uv; upd_mask = mask; upd_mode = mode; wr_data = wr;
    {alu_n, alu_z, alu_v, alu_c} = nzvc;
    cond_req = req; cond_sel = sel;
    nxt = model_next(m_ccr, uv, mask, mode, wr, nzvc);
    nb  = 1'b0;
    if (req && !m_busy) begin
`ifdef CCR_BYPASS_EN
      sb.push_back('{model_pred(nxt, sel), cyc + 1});
`else
      if (uv) begin
        sb.push_back('{model_pred(nxt, sel), cyc + 2});
        nb = 1'b1;
      end else begin
        sb.push_back('{model_pred(m_ccr, sel), cyc + 1});
      end
`endif
    end
    m_busy = nb;
    m_ccr  = nxt;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'b0, 2'b0, 5'b0, 4'b0, 1'b0, 4'd0);
  endtask

  // Result monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("missing_result", 0, 1);
        void'(sb.pop_front());
      end
      if (cond_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          head = sb.pop_front();
          check("result_cycle", cyc, head.due);
          check("cond_true", cond_true, head.exp_true);
          last_true = head.exp_true;
        end
      end else begin
        check("true_hold", cond_true, last_true);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_ccr", ccr, 5'b00000);
    check("rst_valid", cond_valid, 0);
    check("rst_true", cond_true, 0);
    check("rst_busy", cond_busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    // 7FFF+0001: N=1 Z=0 V=1 C=0, then VS and LT back to back.
    drive(1'b1, 5'b11111, 2'b00, 5'b0, 4'b1010, 1'b0, 4'd0);
    drive(1'b0, 5'b0, 2'b00, 5'b0, 4'b0, 1'b1, 4'd9);
    drive(1'b0, 5'b0, 2'b00, 5'b0, 4'b0, 1'b1, 4'd13);
    check("arith_ccr", ccr, 5'b01010);
    idle(2);

    // Extended mode: Z is sticky-cleared.
    drive(1'b1, 5'b11111, 2'b11, 5'b00100, 4'b0, 1'b0, 4'd0);
    drive(1'b1, 5'b11111, 2'b01, 5'b0, 4'b0100, 1'b0, 4'd0);
    check("ext_z_keep", ccr, 5'b00100);
    drive(1'b1, 5'b11111, 2'b01, 5'b0, 4'b0000, 1'b0, 4'd0);
    check("ext_z_clear", ccr, 5'b00000);
    drive(1'b1, 5'b11111, 2'b01, 5'b0, 4'b0100, 1'b1, 4'd7);
    check("ext_z_stay0", ccr, 5'b00000);
    idle(2);

    // Logical mode holds X.
    drive(1'b1, 5'b11111, 2'b11, 5'b11111, 4'b0, 1'b0, 4'd0);
    drive(1'b1, 5'b11111, 2'b10, 5'b0, 4'b0111, 1'b0, 4'd0);
    check("logic_ccr", ccr, 5'b10100);

    // Load mode, partial mask.
    drive(1'b1, 5'b11111, 2'b11, 5'b00000, 4'b0, 1'b0, 4'd0);
    drive(1'b1, 5'b00011, 2'b11, 5'b10101, 4'b0, 1'b0, 4'd0);
    check("load_ccr", ccr, 5'b00001);
    idle(1);

    // Coincident EQ with an update setting Z, then a request while busy.
    drive(1'b1, 5'b11111, 2'b00, 5'b0, 4'b0100, 1'b1, 4'd7);
`ifndef CCR_BYPASS_EN
    check("coinc_busy", cond_busy, 1);
`endif
    drive(1'b0, 5'b0, 2'b00, 5'b0, 4'b0, 1'b1, 4'd0);
    drive(1'b0, 5'b0, 2'b00, 5'b0, 4'b0, 1'b1, 4'd6);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom), 5'($urandom),
            4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
    end
    idle(3);

    // Reset while a coincident request is deferred.
    drive(1'b1, 5'b11111, 2'b11, 5'b11111, 4'b0, 1'b1, 4'd15);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ccr", ccr, 5'b00000);
    check("rst_mid_valid", cond_valid, 0);
    check("rst_mid_busy", cond_busy, 0);
    sb.delete();
    m_ccr = 5'b00000; m_busy = 1'b0; last_true = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);
    drive(1'b0, 5'b0, 2'b00, 5'b0, 4'b0, 1'b1, 4'd7);
    idle(3);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
